fdiv_ctrl: RTL and testbench

FDIV_CTRL -- requirements
Module: fdiv_ctrl

---
 rtl/fdiv_ctrl.sv | 138 +++++++++++++
 tb/tb_fdiv_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_ctrl.sv
// fdiv_ctrl: issue/return controller for a fixed-latency FP32 divider.
// Requests are registered onto the divider inputs, a shadow pipeline tracks
// what was issued, and returning quotients land in a small result FIFO.
// req_ready is credit-based (queued + in flight < DEPTH), so the FIFO can
// never overflow. Operand bits are forwarded untouched in both directions.
module fdiv_ctrl #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_x1,
  input  logic [31:0] req_x2,
  input  logic [4:0]  req_add,
  output logic [31:0] div_x1,
  output logic [31:0] div_x2,
  output logic        div_flag,
  output logic [4:0]  div_add,
  input  logic [31:0] div_y,
  input  logic        div_flagout,
  input  logic [4:0]  div_addout,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_add,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + LATENCY + 2) + 1;
  localparam int BW = $clog2(LATENCY + 2);

  logic [31:0]             x1_q, x2_q;
  logic [4:0]              add_q;
  logic                    flag_q;
  // Stage 0 of the shadow is the div_flag/div_add register itself;
  // stages 1..LATENCY are held here, stage LATENCY lines up with div_flagout.
  logic [LATENCY:1]        sh_flag_q;
  logic [LATENCY:1][4:0]   sh_tag_q;
  logic [36:0]             mem_q [DEPTH];
  logic [AW-1:0]           wr_q, rd_q;
  logic [CW-1:0]           fcount_q, fcount_d;
  logic [CW-1:0]           inflight;
  logic [BW-1:0]           blank_q;
  logic                    err_q, rdy_en_q;
  logic                    issue, push, pop, mismatch;

  assign issue    = req_valid & req_ready;
  assign push     = sh_flag_q[LATENCY];
  assign pop      = wb_valid & wb_ready;
  assign mismatch = (div_flagout != sh_flag_q[LATENCY]) ||
                    (div_flagout && sh_flag_q[LATENCY] && (div_addout != sh_tag_q[LATENCY]));

  // Count of issued requests whose result has not yet been pushed
  always_comb begin
    inflight = CW'(flag_q);
    for (int i = 1; i <= LATENCY; i++) inflight = inflight + CW'(sh_flag_q[i]);
  end

  // rdy_en_q keeps req_ready low while reset is held
  assign req_ready = rdy_en_q && ((fcount_q + inflight) < CW'(DEPTH));
  assign fcount_d  = fcount_q + CW'(push) - CW'(pop);

  assign div_x1   = x1_q;
  assign div_x2   = x2_q;
  assign div_add  = add_q;
  assign div_flag = flag_q;
  assign wb_valid = (fcount_q != '0);
  assign wb_data  = wb_valid ? mem_q[rd_q][31:0]  : 32'h0;
  assign wb_add   = wb_valid ? mem_q[rd_q][36:32] : 5'h0;
  assign err      = err_q;

  // Divider input register: operands hold between issues, flag pulses once
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x1_q   <= '0;
      x2_q   <= '0;
      add_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      flag_q <= issue;
      if (issue) begin
        x1_q  <= req_x1;
        x2_q  <= req_x2;
        add_q <= req_add;
      end
    end
  end

  // Shadow pipeline mirroring the divider's flag/tag path
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_flag_q <= '0;
      sh_tag_q  <= '0;
    end else begin
      sh_flag_q[1] <= flag_q;
      sh_tag_q[1]  <= add_q;
      for (int i = 2; i <= LATENCY; i++) begin
        sh_flag_q[i] <= sh_flag_q[i-1];
        sh_tag_q[i]  <= sh_tag_q[i-1];
      end
    end
  end

  // Result FIFO storage; contents are masked by wb_valid so no reset needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {div_addout, div_y};
  end

  // Result FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q     <= '0;
      rd_q     <= '0;
      fcount_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      fcount_q <= fcount_d;
    end
  end

  // Sticky mismatch flag, ignored while unreset divider stages drain out
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blank_q  <= BW'(LATENCY + 1);
      err_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (blank_q != '0) blank_q <= blank_q - BW'(1);
      else if (mismatch) err_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fdiv_ctrl.sv
// tb_fdiv_ctrl: randomized bench for fdiv_ctrl with a behavioural divider
// and an issue-order scoreboard that predicts ready/valid/data per cycle.
module tb_fdiv_ctrl;
  localparam int LAT = 4;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_x1 = '0, req_x2 = '0;
  logic [4:0]  req_add = '0;
  logic [31:0] div_x1, div_x2, div_y;
  logic        div_flag, div_flagout;
  logic [4:0]  div_add, div_addout;
  logic        wb_valid, wb_ready = 1'b0;
  logic [31:0] wb_data;
  logic [4:0]  wb_add;
  logic        err;
  logic        corrupt = 1'b0;

  int n_tests = 0, n_fail = 0;
  int now = 0;
  int tag_ctr = 0;

  typedef struct { logic [31:0] y; logic [4:0] tag; int avail; } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fdiv_ctrl #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x1(req_x1), .req_x2(req_x2), .req_add(req_add),
    .div_x1(div_x1), .div_x2(div_x2), .div_flag(div_flag), .div_add(div_add),
    .div_y(div_y), .div_flagout(div_flagout), .div_addout(div_addout),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_add(wb_add),
    .err(err)
  );

  // Stand-in divider: the controller never inspects quotient bits, so only
  // the cases that matter are real quotients; the rest is a bit scramble.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40400000 && b == 32'h40000000) return 32'h3FC00000;
    if (b == 32'h0 && a[30:23] == 8'hFF && a[22:0] != 0) return a;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  // Behavioural divider pipeline, deliberately not reset
  logic        p_flag [LAT];
  logic [4:0]  p_tag  [LAT];
  logic [31:0] p_y    [LAT];
  initial for (int i = 0; i < LAT; i++) begin p_flag[i] = 0; p_tag[i] = 0; p_y[i] = 0; end
  always @(posedge clk) begin
    p_flag[0] <= div_flag;
    p_tag[0]  <= div_add;
    p_y[0]    <= ref_div(div_x1, div_x2);
    for (int i = 1; i < LAT; i++) begin
      p_flag[i] <= p_flag[i-1];
      p_tag[i]  <= p_tag[i-1];
      p_y[i]    <= p_y[i-1];
    end
  end
  assign div_flagout = p_flag[LAT-1];
  assign div_addout  = p_tag[LAT-1] ^ {4'b0, corrupt};
  assign div_y       = p_y[LAT-1];

  function automatic bit exp_valid();
    if (exp_q.size() == 0) return 1'b0;
    return exp_q[0].avail <= now;
  endfunction

  function automatic bit exp_ready();
    return exp_q.size() < DEP;
  endfunction

  // Advance one clock edge and update the scoreboard with that edge's handshakes
  task automatic step();
    bit acc, pp;
    exp_t e;
    acc = req_valid && req_ready;
    pp  = wb_valid && wb_ready;
    e.y = ref_div(req_x1, req_x2); e.tag = req_add;
    @(posedge clk);
    now++;
    e.avail = now + LAT + 1;
    if (acc) exp_q.push_back(e);
    if (pp && exp_q.size() > 0) void'(exp_q.pop_front());
    #1;
  endtask

  // Drive n_req random requests and drain, checking every cycle against the scoreboard
  task automatic traffic(input string nm, input int n_req, input int ready_pct, input int max_cyc);
    int sent = 0, cyc = 0;
    while ((sent < n_req || exp_q.size() > 0) && cyc < max_cyc) begin
      @(negedge clk);
      req_valid = (sent < n_req);
      req_x1 = $urandom; req_x2 = $urandom; req_add = 5'(tag_ctr);
      wb_ready = ($urandom_range(99) < ready_pct);
      n_tests++;
      if (req_ready !== exp_ready()) begin
        n_fail++; $display("FAIL %s ready: got %b want %b (t=%0d)", nm, req_ready, exp_ready(), now);
      end
      n_tests++;
      if (wb_valid !== exp_valid()) begin
        n_fail++; $display("FAIL %s wb_valid: got %b want %b (t=%0d)", nm, wb_valid, exp_valid(), now);
      end
      if (wb_valid && wb_ready && exp_q.size() > 0) begin
        n_tests++;
        if ({wb_add, wb_data} !== {exp_q[0].tag, exp_q[0].y}) begin
          n_fail++; $display("FAIL %s data: got %h/%h want %h/%h", nm, wb_add, wb_data, exp_q[0].tag, exp_q[0].y);
        end
      end
      if (req_valid && req_ready) begin sent++; tag_ctr++; end
      step();
      cyc++;
    end
    n_tests++;
    if (cyc >= max_cyc) begin n_fail++; $display("FAIL %s timeout: got %0d cycles want < %0d", nm, cyc, max_cyc); end
    @(negedge clk);
    req_valid = 1'b0; wb_ready = 1'b0;
  endtask

  // Issue one request with an idle FIFO and wait for its result at the head
  task automatic issue_wait(input logic [31:0] a, input logic [31:0] b, input logic [4:0] t, output int edges);
    int w = 0;
    @(negedge clk);
    req_valid = 1'b1; req_x1 = a; req_x2 = b; req_add = t; wb_ready = 1'b1;
    while (req_ready !== 1'b1 && w < 50) begin step(); w++; @(negedge clk); end
    step(); edges = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (wb_valid !== 1'b1 && edges < 30) begin step(); edges++; @(negedge clk); end
    n_tests++;
    if (edges >= 30) begin n_fail++; $display("FAIL issue_wait timeout: got %0d edges want < 30", edges); end
  endtask

  task automatic test_reset();
    #1 rstn = 1'b0;
    @(negedge clk); @(negedge clk);
    n_tests++;
    if ({div_x1, div_x2, div_add, div_flag} !== '0) begin
      n_fail++; $display("FAIL reset div_*: got %h %h %h %b want 0", div_x1, div_x2, div_add, div_flag);
    end
    n_tests++;
    if ({wb_valid, wb_data, wb_add} !== '0) begin
      n_fail++; $display("FAIL reset wb_*: got %b %h %h want 0", wb_valid, wb_data, wb_add);
    end
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset err: got %b want 0", err); end
    n_tests++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset ready: got %b want 0", req_ready); end
    rstn = 1'b1;
    step();
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset ready_after: got %b want 1", req_ready); end
  endtask

  task automatic test_single();
    int edges;
    @(negedge clk);
    req_valid = 1'b1; req_x1 = 32'h40400000; req_x2 = 32'h40000000; req_add = 5'd5; wb_ready = 1'b1;
    step(); edges = 1;
    @(negedge clk);
    req_valid = 1'b0; req_x1 = 32'hDEADBEEF;
    n_tests++;
    if ({div_flag, div_x1, div_x2, div_add} !== {1'b1, 32'h40400000, 32'h40000000, 5'd5}) begin
      n_fail++; $display("FAIL single issue_regs: got %b %h %h %h want 1 40400000 40000000 05", div_flag, div_x1, div_x2, div_add);
    end
    step(); edges++;
    @(negedge clk);
    n_tests++;
    if ({div_flag, div_x1} !== {1'b0, 32'h40400000}) begin
      n_fail++; $display("FAIL single hold: got %b %h want 0 40400000", div_flag, div_x1);
    end
    while (wb_valid !== 1'b1 && edges < 30) begin step(); edges++; @(negedge clk); end
    n_tests++;
    if (edges != LAT + 2) begin n_fail++; $display("FAIL single latency: got %0d want %0d", edges, LAT + 2); end
    n_tests++;
    if ({wb_data, wb_add} !== {32'h3FC00000, 5'd5}) begin
      n_fail++; $display("FAIL single result: got %h/%h want 3fc00000/05", wb_data, wb_add);
    end
    step();
    @(negedge clk);
    wb_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int acc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_x1 = $urandom; req_x2 = $urandom; req_add = 5'(i); wb_ready = 1'b0;
      n_tests++;
      if (req_ready !== exp_ready()) begin
        n_fail++; $display("FAIL bp ready: got %b want %b (i=%0d)", req_ready, exp_ready(), i);
      end
      if (req_ready) acc++;
      step();
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_tests++;
    if (acc != DEP) begin n_fail++; $display("FAIL bp accepts: got %0d want %0d", acc, DEP); end
    n_tests++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp full_ready: got %b want 0", req_ready); end
    wb_ready = 1'b1;
    n_tests++;
    if ({wb_valid, wb_add, wb_data} !== {1'b1, exp_q[0].tag, exp_q[0].y}) begin
      n_fail++; $display("FAIL bp head: got %b %h/%h want 1 %h/%h", wb_valid, wb_add, wb_data, exp_q[0].tag, exp_q[0].y);
    end
    step();
    @(negedge clk);
    wb_ready = 1'b0;
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp ready_after_pop: got %b want 1", req_ready); end
    step();
    traffic("bp_drain", 0, 100, 60);
  endtask

  task automatic test_stream();
    tag_ctr = 0;
    traffic("stream", 100, 100, 600);
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL stream err: got %b want 0", err); end
  endtask

  task automatic test_random();
    traffic("random", 60, 40, 900);
  endtask

  task automatic test_special();
    int edges;
    issue_wait(32'h7FC00000, 32'h00000000, 5'd17, edges);
    n_tests++;
    if ({wb_data, wb_add} !== {32'h7FC00000, 5'd17}) begin
      n_fail++; $display("FAIL special nan: got %h/%h want 7fc00000/11", wb_data, wb_add);
    end
    step();
    issue_wait(32'h00000001, 32'h7F800000, 5'd31, edges);
    n_tests++;
    if ({wb_data, wb_add} !== {32'h00000001 ^ 32'h00007F80, 5'd31}) begin
      n_fail++; $display("FAIL special denorm: got %h/%h want %h/1f", wb_data, wb_add, 32'h00000001 ^ 32'h00007F80);
    end
    step();
    @(negedge clk);
    wb_ready = 1'b0;
  endtask

  task automatic test_mismatch();
    int w = 0;
    @(negedge clk);
    req_valid = 1'b1; req_x1 = $urandom; req_x2 = $urandom; req_add = 5'd12; wb_ready = 1'b0;
    step();
    @(negedge clk);
    req_valid = 1'b0;
    while (div_flagout !== 1'b1 && w < 20) begin step(); w++; @(negedge clk); end
    n_tests++;
    if (w >= 20) begin n_fail++; $display("FAIL mismatch wait: got %0d cycles want < 20", w); end
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL mismatch pre_err: got %b want 0", err); end
    corrupt = 1'b1;
    exp_q[0].tag = exp_q[0].tag ^ 5'd1;
    step();
    @(negedge clk);
    corrupt = 1'b0;
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL mismatch err_set: got %b want 1", err); end
    repeat (6) step();
    @(negedge clk);
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL mismatch err_sticky: got %b want 1", err); end
    traffic("mismatch_drain", 0, 100, 40);
  endtask

  task automatic test_reset_mid();
    bit bad_v = 0, bad_e = 0;
    tag_ctr = 0;
    // two results queued
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_x1 = $urandom; req_x2 = $urandom; req_add = 5'(i); wb_ready = 1'b0;
      step();
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (LAT + 2) step();
    // two more in flight inside the divider
    for (int i = 2; i < 4; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_x1 = $urandom; req_x2 = $urandom; req_add = 5'(i);
      step();
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_tests++;
    if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid queued: got %b want 1", wb_valid); end
    step();
    @(negedge clk);
    rstn = 1'b0;
    exp_q.delete();
    #1;
    n_tests++;
    if ({wb_valid, err, req_ready, div_flag} !== 4'b0) begin
      n_fail++; $display("FAIL rstmid during: got %b%b%b%b want 0000", wb_valid, err, req_ready, div_flag);
    end
    step();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < LAT + 4; i++) begin
      step();
      @(negedge clk);
      if (wb_valid !== 1'b0) bad_v = 1;
      if (err !== 1'b0) bad_e = 1;
    end
    n_tests++;
    if (bad_v) begin n_fail++; $display("FAIL rstmid stale_push: got wb_valid=1 want 0"); end
    n_tests++;
    if (bad_e) begin n_fail++; $display("FAIL rstmid blank: got err=1 want 0"); end
    traffic("rstmid_after", 12, 70, 200);
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL rstmid err_final: got %b want 0", err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_random();
    test_special();
    test_mismatch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
